// File: rtl/mips_instr_encoder.sv
// Assembles decoded instruction fields into 32-bit MIPS words behind a
// valid/ready input and a 2-entry output FIFO, with wrapping legal/illegal counters.
module mips_instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [2:0]  in_func,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_illegal,
    output logic [15:0] enc_count,
    output logic [15:0] ill_count
);

    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_I    = 3'd1,
        KIND_LW   = 3'd2,
        KIND_SW   = 3'd3,
        KIND_BEQ  = 3'd4,
        KIND_J    = 3'd5,
        KIND_BAD6 = 3'd6,
        KIND_BAD7 = 3'd7
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    kind_e       kind;
    logic [31:0] enc_word;
    logic        enc_illegal;
    logic [5:0]  funct;
    logic [5:0]  iop;

    logic [32:0] fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fifo_count;
    logic        push;
    logic        pop;
    logic [32:0] head;

    assign kind = kind_e'(in_kind);

    // Encoder: illegal kind/func combinations collapse to an all-zero word.
    always_comb begin
        enc_word    = 32'h0000_0000;
        enc_illegal = 1'b0;
        funct       = 6'h00;
        iop         = 6'h00;
        case (in_func)
            3'd0:    funct = 6'h20;
            3'd1:    funct = 6'h22;
            3'd2:    funct = 6'h24;
            3'd3:    funct = 6'h25;
            3'd4:    funct = 6'h2A;
            default: funct = 6'h00;
        endcase
        case (in_func)
            3'd0:    iop = OP_ADDI;
            3'd2:    iop = OP_ANDI;
            3'd3:    iop = OP_ORI;
            3'd4:    iop = OP_SLTI;
            default: iop = 6'h00;
        endcase
        case (kind)
            KIND_R: begin
                if (in_func <= 3'd4) begin
                    enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'h00, funct};
                end else begin
                    enc_illegal = 1'b1;
                end
            end
            KIND_I: begin
                if (in_func == 3'd1 || in_func >= 3'd5) begin
                    enc_illegal = 1'b1;
                end else begin
                    enc_word = {iop, in_rs, in_rt, in_imm};
                end
            end
            KIND_LW:  enc_word = {OP_LW,  in_rs, in_rt, in_imm};
            KIND_SW:  enc_word = {OP_SW,  in_rs, in_rt, in_imm};
            KIND_BEQ: enc_word = {OP_BEQ, in_rs, in_rt, in_imm};
            KIND_J:   enc_word = {OP_J, in_target};
            default:  enc_illegal = 1'b1;
        endcase
    end

    assign in_ready  = (fifo_count != 2'd2);
    assign out_valid = (fifo_count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = fifo_mem[rd_ptr];

    // An empty FIFO presents zeros rather than stale storage.
    assign out_instr   = out_valid ? head[31:0] : 32'h0000_0000;
    assign out_illegal = out_valid ? head[32]   : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {enc_illegal, enc_word};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_count <= 16'h0000;
            ill_count <= 16'h0000;
        end else if (push) begin
            if (enc_illegal) begin
                ill_count <= ill_count + 16'd1;
            end else begin
                enc_count <= enc_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: expected words are queued at
// acceptance and compared as the DUT pops them from its FIFO.
module tb_mips_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [2:0]  in_func;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_illegal;
    logic [15:0] enc_count;
    logic [15:0] ill_count;

    int          check_cnt = 0;
    int          pass_cnt  = 0;
    int          pop_cnt   = 0;
    logic [32:0] scoreboard [$];
    logic [15:0] exp_enc;
    logic [15:0] exp_ill;
    logic        rand_ready = 1'b0;

    mips_instr_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_func(in_func),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_illegal(out_illegal),
        .enc_count(enc_count), .ill_count(ill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoding, written from the instruction-format tables: {illegal, word}.
    function automatic logic [32:0] model(input logic [2:0] kind, input logic [2:0] func,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [15:0] imm,
                                          input logic [25:0] target);
        logic [5:0] f;
        case (kind)
            3'd0: begin
                case (func)
                    3'd0: f = 6'h20;
                    3'd1: f = 6'h22;
                    3'd2: f = 6'h24;
                    3'd3: f = 6'h25;
                    3'd4: f = 6'h2A;
                    default: return {1'b1, 32'h0};
                endcase
                return {1'b0, 6'h00, rs, rt, rd, 5'h00, f};
            end
            3'd1: begin
                case (func)
                    3'd0: f = 6'h08;
                    3'd2: f = 6'h0C;
                    3'd3: f = 6'h0D;
                    3'd4: f = 6'h0A;
                    default: return {1'b1, 32'h0};
                endcase
                return {1'b0, f, rs, rt, imm};
            end
            3'd2: return {1'b0, 6'h23, rs, rt, imm};
            3'd3: return {1'b0, 6'h2B, rs, rt, imm};
            3'd4: return {1'b0, 6'h04, rs, rt, imm};
            3'd5: return {1'b0, 6'h02, target};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // Drives one request and holds it until accepted; leaves in_valid high.
    task automatic applyStimulus(input logic [2:0] kind, input logic [2:0] func,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [15:0] imm,
                                 input logic [25:0] target, output int waited);
        logic [32:0] e;
        in_kind = kind; in_func = func; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = target; in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        e = model(kind, func, rs, rt, rd, imm, target);
        scoreboard.push_back(e);
        if (e[32]) exp_ill++;
        else exp_enc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic pulseReset();
        #1 rst = 1'b1;
        scoreboard.delete();
        exp_enc = 16'h0;
        exp_ill = 16'h0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic randomLegal(output logic [2:0] k, output logic [2:0] f);
        logic [32:0] e;
        do begin
            k = 3'($urandom_range(0, 5));
            f = 3'($urandom_range(0, 7));
            e = model(k, f, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        end while (e[32]);
    endtask

    // Compare the head at the negedge preceding the edge that pops it.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst && out_valid && out_ready) begin
            pop_cnt++;
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected_pop", {31'd0, out_illegal, out_instr}, 64'd0);
            end else begin
                e = scoreboard.pop_front();
                checkOutput("fifo_head", {31'd0, out_illegal, out_instr}, {31'd0, e});
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int w;
        int p0;
        logic [2:0] k;
        logic [2:0] f;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_kind = '0; in_func = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; in_target = '0;
        exp_enc = 16'h0; exp_ill = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_instr", 64'(out_instr), 64'd0);
        checkOutput("reset_enc_count", 64'(enc_count), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed encodings");
        out_ready = 1'b1;
        applyStimulus(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h3FFFFFF, w);
        idle();
        @(negedge clk);
        checkOutput("latency_valid", 64'(out_valid), 64'd1);
        checkOutput("add_word", 64'(out_instr), 64'h00221820);
        @(posedge clk); #1;
        applyStimulus(3'd2, 3'd6, 5'd29, 5'd8, 5'd31, 16'h0004, 26'h1, w);
        idle();
        @(negedge clk);
        checkOutput("lw_word", 64'(out_instr), 64'h8FA80004);
        @(posedge clk); #1;
        applyStimulus(3'd4, 3'd0, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'h0, w);
        idle();
        @(negedge clk);
        checkOutput("beq_word", 64'(out_instr), 64'h1085FFFF);
        @(posedge clk); #1;
        applyStimulus(3'd1, 3'd1, 5'd7, 5'd9, 5'd0, 16'h1234, 26'h0, w);
        idle();
        @(negedge clk);
        checkOutput("illegal_word", 64'(out_instr), 64'h0);
        checkOutput("illegal_flag", 64'(out_illegal), 64'd1);
        checkOutput("ill_count", 64'(ill_count), 64'd1);
        checkOutput("enc_count_after_ill", 64'(enc_count), 64'd3);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("empty_out_instr", 64'(out_instr), 64'd0);
        checkOutput("empty_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] backpressure");
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(3'd5, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000111, w);
        applyStimulus(3'd3, 3'd2, 5'd3, 5'd4, 5'd0, 16'h0010, 26'd0, w);
        in_kind = 3'd0; in_func = 3'd3; in_rs = 5'd10; in_rt = 5'd11; in_rd = 5'd12;
        @(negedge clk);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        checkOutput("full_not_counted", 64'(enc_count), 64'(exp_enc));
        out_ready = 1'b1;
        applyStimulus(3'd0, 3'd3, 5'd10, 5'd11, 5'd12, 16'd0, 26'd0, w);
        idle();
        checkOutput("third_accept_delay", 64'(w), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("drain_empty", 64'(scoreboard.size()), 64'd0);
        checkOutput("enc_count_bp", 64'(enc_count), 64'(exp_enc));

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(3'd2, 3'd0, 5'd1, 5'd1, 5'd1, 16'h1, 26'd0, w);
        applyStimulus(3'd2, 3'd0, 5'd2, 5'd2, 5'd2, 16'h2, 26'd0, w);
        idle();
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_enc_count", 64'(enc_count), 64'd0);
        checkOutput("midrst_out_instr", 64'(out_instr), 64'd0);
        scoreboard.delete();
        exp_enc = 16'h0; exp_ill = 16'h0;
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        applyStimulus(3'd5, 3'd4, 5'd9, 5'd9, 5'd9, 16'hFFFF, 26'h0000040, w);
        idle();
        @(negedge clk);
        checkOutput("j_after_reset", 64'(out_instr), 64'h08000040);
        @(posedge clk); #1;

        $display("[TB] streaming");
        pulseReset();
        out_ready = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 20; i++) begin
            randomLegal(k, f);
            applyStimulus(k, f, 5'($urandom), 5'($urandom), 5'($urandom),
                          16'($urandom), 26'($urandom), w);
            checkOutput("stream_no_stall", 64'(w), 64'd0);
        end
        idle();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("stream_pops", 64'(pop_cnt - p0), 64'd20);
        checkOutput("stream_enc_count", 64'(enc_count), 64'd20);

        $display("[TB] random mix with random out_ready");
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(3'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                          5'($urandom), 16'($urandom), 26'($urandom), w);
        end
        idle();
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mix_drained", 64'(scoreboard.size()), 64'd0);
        checkOutput("mix_enc_count", 64'(enc_count), 64'(exp_enc));
        checkOutput("mix_ill_count", 64'(ill_count), 64'(exp_ill));

        $display("[TB] counter wrap");
        pulseReset();
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            randomLegal(k, f);
            applyStimulus(k, f, 5'($urandom), 5'($urandom), 5'($urandom),
                          16'($urandom), 26'($urandom), w);
        end
        idle();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("wrap_enc_count", 64'(enc_count), 64'd1);
        checkOutput("wrap_model", 64'(enc_count), 64'(exp_enc));
        checkOutput("wrap_drained", 64'(scoreboard.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
